// File: rtl/mem_fill_check_pkg.sv
// Shared state codes, saturation limit and address-derived pattern for mem_fill_check.
package mem_fill_check_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

  // Expected word for an address: (addr + seed) truncated to the memory width.
  function automatic logic [31:0] exp_pattern(input logic [31:0] addr,
                                              input logic [31:0] seed,
                                              input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? SAT_MAX : ((32'd1 << width) - 32'd1);
    return (addr + seed) & mask;
  endfunction

endpackage

// File: rtl/mem_fill_check_if.sv
// Simple dual-port memory bus between the fill/check initiator and a block-RAM wrapper.
interface mem_fill_check_if #(
  parameter int unsigned WID_MEM = 1
) ();

  logic [31:0]        raddr;
  logic [31:0]        waddr;
  logic [WID_MEM-1:0] din;
  logic               mem_we;
  logic [WID_MEM-1:0] dout;

  modport master (
    output raddr,
    output waddr,
    output din,
    output mem_we,
    input  dout
  );

  modport slave (
    input  raddr,
    input  waddr,
    input  din,
    input  mem_we,
    output dout
  );

endinterface

// File: rtl/mem_err_tracker.sv
// Saturating event counter with capture of the address of the first event since clear.
module mem_err_tracker
  import mem_fill_check_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        mismatch,
  input  logic [31:0] addr,
  output logic [31:0] count,
  output logic [31:0] first_addr,
  output logic        first_valid
);

  logic [31:0] count_q, count_d;
  logic [31:0] first_addr_q, first_addr_d;
  logic        first_valid_q, first_valid_d;

  always_comb begin
    count_d       = count_q;
    first_addr_d  = first_addr_q;
    first_valid_d = first_valid_q;
    if (clear) begin
      count_d       = '0;
      first_addr_d  = '0;
      first_valid_d = 1'b0;
    end else if (mismatch) begin
      if (count_q != SAT_MAX) begin
        count_d = count_q + 32'd1;
      end
      if (!first_valid_q) begin
        first_addr_d  = addr;
        first_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      first_addr_q  <= '0;
      first_valid_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      first_addr_q  <= first_addr_d;
      first_valid_q <= first_valid_d;
    end
  end

  assign count       = count_q;
  assign first_addr  = first_addr_q;
  assign first_valid = first_valid_q;

endmodule

// File: rtl/mem_fill_check.sv
// Fills a memory sweep range with an address pattern, reads it back and counts mismatches.
// Optional MEM_FILL_CHECK_SCRUB_EN rewrites failing words during CHECK and adds scrub_count.
module mem_fill_check
  import mem_fill_check_pkg::*;
#(
  parameter int unsigned WID_MEM   = 1,
  parameter int unsigned DEPTH_MEM = 16384,
  parameter int unsigned LAST_ADDR = DEPTH_MEM - 2,
  parameter int unsigned PARK_ADDR = DEPTH_MEM - 1,
  parameter int unsigned SEED      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    check_only,
  input  logic                    abort,
  mem_fill_check_if.master        mem,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             err_count,
  output logic [31:0]             first_err_addr,
  output logic                    first_err_valid
`ifdef MEM_FILL_CHECK_SCRUB_EN
  ,
  output logic [31:0]             scrub_count
`endif
);

  localparam int unsigned        AW      = (DEPTH_MEM > 2) ? $clog2(DEPTH_MEM) : 1;
  localparam logic [AW-1:0]      LAST_AW = AW'(LAST_ADDR);
  localparam logic [31:0]        PARK_W  = 32'(PARK_ADDR);
  localparam logic [31:0]        SEED_W  = 32'(SEED);

  logic [2:0]         state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [WID_MEM-1:0] din_q, din_d;
  logic [31:0]        raddr_q, raddr_d;
  logic               cmp_valid_q, cmp_valid_d;
  logic [31:0]        cmp_addr_q, cmp_addr_d;
  logic               clear_c;
  logic               mismatch;
  logic [WID_MEM-1:0] cmp_exp;

  // Read data for the address presented last cycle arrives now.
  assign cmp_exp  = WID_MEM'(exp_pattern(cmp_addr_q, SEED_W, WID_MEM));
  assign mismatch = cmp_valid_q && (mem.dout != cmp_exp);

`ifdef MEM_FILL_CHECK_SCRUB_EN
  logic        scrub_fire;
  logic [31:0] scrub_first_addr_unused;
  logic        scrub_first_valid_unused;
  assign scrub_fire = mismatch && !abort;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    clear_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear_c = 1'b1;
          addr_d  = '0;
          state_d = check_only ? ST_CHECK : ST_FILL;
        end
      end
      ST_FILL, ST_CHECK: begin
        if (addr_q == LAST_AW) begin
          addr_d  = '0;
          state_d = (state_q == ST_FILL) ? ST_CHECK : ST_DRAIN;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && busy_q) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end

    // Outputs are registered, so they are derived from the next state.
    busy_d   = (state_d == ST_FILL) || (state_d == ST_CHECK) || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_DONE);
    mem_we_d = 1'b0;
    waddr_d  = PARK_W;
    din_d    = '0;
    raddr_d  = '0;
    if (state_d == ST_FILL) begin
      mem_we_d = 1'b1;
      waddr_d  = 32'(addr_d);
      din_d    = WID_MEM'(exp_pattern(32'(addr_d), SEED_W, WID_MEM));
    end
    if (state_d == ST_CHECK) begin
      raddr_d = 32'(addr_d);
    end
`ifdef MEM_FILL_CHECK_SCRUB_EN
    if (scrub_fire) begin
      mem_we_d = 1'b1;
      waddr_d  = cmp_addr_q;
      din_d    = cmp_exp;
    end
`endif
    cmp_valid_d = (state_q == ST_CHECK) && !abort;
    cmp_addr_d  = raddr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      waddr_q     <= PARK_W;
      din_q       <= '0;
      raddr_q     <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      waddr_q     <= waddr_d;
      din_q       <= din_d;
      raddr_q     <= raddr_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
    end
  end

  mem_err_tracker u_err (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear_c),
    .mismatch    (mismatch),
    .addr        (cmp_addr_q),
    .count       (err_count),
    .first_addr  (first_err_addr),
    .first_valid (first_err_valid)
  );

`ifdef MEM_FILL_CHECK_SCRUB_EN
  mem_err_tracker u_scrub (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear_c),
    .mismatch    (scrub_fire),
    .addr        (cmp_addr_q),
    .count       (scrub_count),
    .first_addr  (scrub_first_addr_unused),
    .first_valid (scrub_first_valid_unused)
  );
`endif

  assign mem.raddr  = raddr_q;
  assign mem.waddr  = waddr_q;
  assign mem.din    = din_q;
  assign mem.mem_we = mem_we_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mem_fill_check.sv
// Bench for mem_fill_check: behavioural memory plus a golden content array as reference.
module tb_mem_fill_check;

  localparam int unsigned WID   = 3;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned LAST  = DEPTH - 2;
  localparam int unsigned PARK  = DEPTH - 1;
  localparam int unsigned SEED  = 5;
  localparam int          N     = LAST + 1;

  logic        clk = 1'b0;
  logic        reset, start, check_only, abort;
  logic        busy, done, first_err_valid;
  logic [31:0] err_count, first_err_addr;
`ifdef MEM_FILL_CHECK_SCRUB_EN
  logic [31:0] scrub_count;
`endif
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [2:0]  bd_data;
  logic [2:0]  mem [DEPTH];
  int          golden [DEPTH];
  int          checks = 0;
  int          errors = 0;

  mem_fill_check_if #(.WID_MEM(WID)) mif ();

  mem_fill_check #(
    .WID_MEM   (WID),
    .DEPTH_MEM (DEPTH),
    .LAST_ADDR (LAST),
    .PARK_ADDR (PARK),
    .SEED      (SEED)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .check_only      (check_only),
    .abort           (abort),
    .mem             (mif),
    .busy            (busy),
    .done            (done),
    .err_count       (err_count),
    .first_err_addr  (first_err_addr),
    .first_err_valid (first_err_valid)
`ifdef MEM_FILL_CHECK_SCRUB_EN
    ,
    .scrub_count     (scrub_count)
`endif
  );

  always #5 clk = ~clk;

  // Block RAM: writes every clock, registered read, backdoor port for corruption.
  always @(posedge clk) begin
    mem[mif.waddr[11:0]] <= mif.din;
    if (bd_we) mem[bd_addr] <= bd_data;
    mif.dout <= mem[mif.raddr[11:0]];
  end

  function automatic int exp_of(input int a);
    return (a + SEED) % (1 << WID);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},        32'(busy), 0);
    chk({tag, "_done"},        32'(done), 0);
    chk({tag, "_mem_we"},      32'(mif.mem_we), 0);
    chk({tag, "_raddr"},       mif.raddr, 0);
    chk({tag, "_waddr"},       mif.waddr, PARK);
    chk({tag, "_din"},         32'(mif.din), 0);
    chk({tag, "_err_count"},   err_count, 0);
    chk({tag, "_first_addr"},  first_err_addr, 0);
    chk({tag, "_first_valid"}, 32'(first_err_valid), 0);
  endtask

  task automatic bd_write(input int a, input int d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = 12'(a); bd_data = 3'(d);
    @(posedge clk); #1;
    bd_we = 1'b0;
    golden[a] = d % (1 << WID);
  endtask

  task automatic mem_vs_golden(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < N; a++) if (int'(mem[a]) != golden[a]) bad++;
    chk(tag, 32'(bad), 0);
  endtask

  // One complete pass; the golden array predicts counts, first address and latency.
  task automatic run_pass(input bit co, input bit poke);
    int exp_err, exp_first, lat, exp_lat;
    if (!co) for (int a = 0; a < N; a++) golden[a] = exp_of(a);
    exp_err = 0; exp_first = 0;
    for (int a = 0; a < N; a++) begin
      if (golden[a] != exp_of(a)) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end
    exp_lat = co ? N + 2 : 2 * N + 2;
    @(negedge clk);
    start = 1'b1; check_only = co;
    @(posedge clk); #1;
    start = 1'b0; check_only = 1'b0;
    lat = 1;
    chk("busy_after_start", 32'(busy), 1);
    chk("err_cleared_by_start", err_count, 0);
    chk("valid_cleared_by_start", 32'(first_err_valid), 0);
    while (done !== 1'b1 && lat < 3 * N) begin
      if (poke && lat == 50) begin start = 1'b1; check_only = ~co; end
      else if (poke && lat == 51) begin start = 1'b0; check_only = 1'b0; end
      @(posedge clk); #1;
      lat++;
    end
    chk("done_latency", 32'(lat), 32'(exp_lat));
    chk("err_count", err_count, 32'(exp_err));
    chk("first_err_valid", 32'(first_err_valid), (exp_err != 0) ? 32'd1 : 32'd0);
    chk("first_err_addr", first_err_addr, 32'(exp_first));
`ifdef MEM_FILL_CHECK_SCRUB_EN
    chk("scrub_count", scrub_count, 32'(exp_err));
    for (int a = 0; a < N; a++) golden[a] = exp_of(a);
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    int r, lat, seen_done;
    reset = 1'b1; start = 1'b0; check_only = 1'b0; abort = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int a = 0; a < DEPTH; a++) golden[a] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b0;

    // Full pass against a clean memory.
    run_pass(1'b0, 1'b0);
    chk("word100_readback", 32'(mem[100]), 1);
    mem_vs_golden("fill_contents");

    // Single corrupted word found by a check-only pass.
    bd_write(100, 0);
    run_pass(1'b1, 1'b0);
    bd_write(100, exp_of(100));

    // Idle cycles park the write port on the scratch word.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      chk("idle_mem_we", 32'(mif.mem_we), 0);
      chk("idle_waddr", mif.waddr, PARK);
      chk("idle_din", 32'(mif.din), 0);
    end
    chk("idle_raddr", mif.raddr, 0);
    mem_vs_golden("idle_contents");

    // Reset in the middle of FILL, then a pass with a start pulse while busy.
    @(negedge clk);
    start = 1'b1; check_only = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!(mif.mem_we === 1'b1 && mif.waddr == 32'd2000) && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("reached_fill_2000", mif.waddr, 2000);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("midfill_rst");
    reset = 1'b0;
    run_pass(1'b0, 1'b1);

    // Abort at a random point in CHECK keeps partial results and gives no done.
    bd_write(5, exp_of(5) ^ 1);
    r = int'($urandom_range(20, 4000));
    @(negedge clk);
    start = 1'b1; check_only = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; check_only = 1'b0;
    lat = 1;
    while (lat < r) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_before_abort", 32'(busy), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_raddr", mif.raddr, 0);
    chk("abort_err_count", err_count, 1);
    chk("abort_first_addr", first_err_addr, 5);
    chk("abort_first_valid", 32'(first_err_valid), 1);
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1;
    end
    chk("no_done_after_abort", 32'(seen_done), 0);
    bd_write(5, exp_of(5));

    // Random corruption, predicted by the golden array.
    for (int i = 0; i < 6; i++) begin
      bd_write(int'($urandom_range(0, LAST)), int'($urandom_range(0, 7)));
    end
    run_pass(1'b1, 1'b0);
    run_pass(1'b0, 1'b0);
    mem_vs_golden("refill_contents");

`ifdef MEM_FILL_CHECK_SCRUB_EN
    // Scrubbing repairs corrupted words during a check-only pass.
    bd_write(100, exp_of(100) ^ 3);
    bd_write(200, exp_of(200) ^ 1);
    run_pass(1'b1, 1'b0);
    mem_vs_golden("scrubbed_contents");
    run_pass(1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_fill_check.md
# mem_fill_check

Sequential initiator for the block-RAM `memory` wrapper's simple dual-port interface (`raddr`/`waddr`/`din`/`dout`).
- On a start pulse it optionally fills a sweep range with an address-derived pattern.
- It then reads every word back and compares it against the same pattern.
- It reports a saturating mismatch count and the first failing address.
- It sits beside a memory instance in the memory-reinit test designs and verifies that reinitialised content is intact.

## Interface
Parameters:
- `WID_MEM`, 1, data width of the attached memory.
- `DEPTH_MEM`, 16384, word count of the attached memory.
- `LAST_ADDR`, DEPTH_MEM-2, last swept address; the sweep covers 0..LAST_ADDR, so N = LAST_ADDR+1. Requires 0 ≤ LAST_ADDR < PARK_ADDR.
- `PARK_ADDR`, DEPTH_MEM-1, scratch word that receives the harmless write on idle cycles.
- `SEED`, 0, pattern offset.

Ports:
- `clk` in 1 — clock.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — begin a pass; sampled only in IDLE.
- `check_only` in 1 — sampled with `start`; 1 = skip FILL.
- `abort` in 1 — return to IDLE; no `done` pulse.
- `raddr` out 32 — memory read address.
- `waddr` out 32 — memory write address.
- `din` out WID_MEM — memory write data.
- `mem_we` out 1 — write-intent flag.
- `dout` in WID_MEM — memory read data; 1-cycle registered latency.
- `busy` out 1 — pass in progress.
- `done` out 1 — one-cycle pulse at the end of a pass.
- `err_count` out 32 — mismatch count.
- `first_err_addr` out 32 — address of the first mismatch.
- `first_err_valid` out 1 — `first_err_addr` holds a captured value.

## Operation
- The memory writes on every clock. Whenever `mem_we`=0 the block drives `waddr`=PARK_ADDR and `din`=0, so no swept word is ever disturbed.
- Expected value: exp(a) = (a + SEED) mod 2^WID_MEM.
- FSM states: IDLE, FILL, CHECK, DRAIN, DONE.
  - IDLE → FILL on `start` with `check_only`=0.
  - IDLE → CHECK on `start` with `check_only`=1.
  - `start` clears `err_count`, `first_err_*` and the address counter.
- FILL: one write per cycle, `mem_we`=1, `waddr`=a, `din`=exp(a), for a = 0..LAST_ADDR. After the last write the FSM goes to CHECK.
- CHECK: `raddr`=a for a = 0..LAST_ADDR, one per cycle. A one-cycle-delayed copy of the address is compared against `dout` in the following cycle. After the last address the FSM goes to DRAIN, where the final compare happens.
- DONE: `done`=1 for one cycle, then IDLE.
- Results hold until the next accepted `start`.
- Mismatch handling:
  - `err_count` increments by one per mismatch and saturates at 2^32-1.
  - The first mismatch captures its address and sets `first_err_valid`.
- `raddr` outside CHECK is 0.
- `start` while `busy`=1 is ignored.
- `abort` is honoured in any busy state: next cycle IDLE, `busy`=0, results keep their partial values.
- `reset`, including mid-pass, forces IDLE on the next edge. Reset values: `busy`=0, `done`=0, `mem_we`=0, `raddr`=0, `waddr`=PARK_ADDR, `din`=0, `err_count`=0, `first_err_addr`=0, `first_err_valid`=0.

## Timing
- `start` is accepted at edge k; `busy`=1 from cycle k+1 until `done` is asserted.
- Full pass:
  - FILL occupies cycles k+1..k+N.
  - CHECK occupies k+N+1..k+2N.
  - DRAIN is k+2N+1.
  - `done` is in cycle k+2N+2, with final counts already visible.
- Check-only pass: `done` in cycle k+N+2.
- Compare for the address presented in cycle c occurs in cycle c+1, and the counters update at the end of c+1.
- N=1 is legal: the write committed at the end of FILL is visible to the first CHECK read.

## Configuration
- `MEM_FILL_CHECK_SCRUB_EN` defined:
  - A mismatch detected in cycle t causes `mem_we`=1, `waddr`=failing address, `din`=expected value in cycle t+1.
  - The sweep continues without stall.
  - A 32-bit saturating `scrub_count` output port is added.
  - The same address is never both read and scrubbed in one cycle, because the read pointer is already two addresses ahead.
- Undefined: CHECK never writes, and no `scrub_count` port exists.

## Structure
- Package `mem_fill_check_pkg` holds:
  - the state enum;
  - the `exp_pattern(addr, seed, width)` function;
  - the saturation maximum constant.
- Sub-module `mem_err_tracker` holds the saturating counter(s) and first-error capture:
  - inputs: `clk`, `reset`, `clear`, `mismatch`, `addr`;
  - instantiated once per counter.

## Test plan
All scenarios use WID_MEM=3, DEPTH_MEM=4096, SEED=5, so N=4095.
1. Start a full pass at cycle k against a fault-free memory → `done` in k+8192; `err_count`=0; `first_err_valid`=0; readback of word 100 = 1.
2. After a fill, backdoor-write word 100 to 0 (exp=1), then start with `check_only`=1 → `err_count`=1, `first_err_addr`=100, `done` in k+4097.
3. Stay in IDLE for 100 cycles → `mem_we`=0, `waddr`=4095, `din`=0 throughout; words 0..4094 unchanged.
4. Assert `reset` mid-FILL at address 2000 → next cycle `busy`=0 and all outputs at reset values; a new full pass then completes with `err_count`=0.
5. Pulse `start` while busy, and pulse `abort` in CHECK → the start is ignored; after the abort, `busy`=0 and no `done` pulse occurs.
6. With `MEM_FILL_CHECK_SCRUB_EN`, corrupt words 100 and 200, then run a check-only pass → `err_count`=2 and `scrub_count`=2; a second check-only pass gives `err_count`=0.
